gray_updown_cnt: RTL and testbench

Parametrised up/down Gray-code counter, next generation of the FIFO pointer counter. It adds:

- direction control, synchronous clear and binary parallel load;
- selectable wrap or saturate behaviour;
- registered binary shadow, terminal flags and a combinational next-value output for look-ahead full/empty logic.

It sits in the FIFO pointer path and in any CDC path that crosses a multi-bit count between clock domains.

---
 rtl/gray_updown_cnt_pkg.sv | 7 +
 rtl/bin_to_gray.sv | 11 +
 rtl/gray_to_bin.sv | 16 +
 rtl/gray_updown_cnt.sv | 84 ++++++++
 tb/tb_gray_updown_cnt.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gray_updown_cnt_pkg.sv
// rtl/gray_updown_cnt_pkg.sv - shared mode encodings for the gray up/down counter
package gray_updown_cnt_pkg;

  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;

endpackage

// File: rtl/bin_to_gray.sv
// rtl/bin_to_gray.sv - binary to Gray code conversion, one XOR stage
module bin_to_gray #(
  parameter int SIZE = 4
) (
  input  logic [SIZE-1:0] bin,
  output logic [SIZE-1:0] gray
);

  assign gray = bin ^ (bin >> 1);

endmodule

// File: rtl/gray_to_bin.sv
// rtl/gray_to_bin.sv - Gray code to binary conversion, prefix XOR per bit
module gray_to_bin #(
  parameter int SIZE = 4
) (
  input  logic [SIZE-1:0] gray,
  output logic [SIZE-1:0] bin
);

  always_comb begin
    bin = '0;
    for (int i = 0; i < SIZE; i++) begin
      bin[i] = ^(gray >> i);
    end
  end

endmodule

// File: rtl/gray_updown_cnt.sv
// rtl/gray_updown_cnt.sv - up/down Gray counter with clear, load, wrap/saturate
module gray_updown_cnt
  import gray_updown_cnt_pkg::*;
#(
  parameter int SIZE = 4,
  parameter int MODE = MODE_WRAP
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            up,
  input  logic            clr,
  input  logic            load,
  input  logic [SIZE-1:0] load_bin,
  output logic [SIZE-1:0] cnt_gray,
  output logic [SIZE-1:0] cnt_bin,
  output logic [SIZE-1:0] cnt_gray_nxt,
  output logic            at_max,
  output logic            at_min,
  output logic            wrap
);

  localparam logic [SIZE-1:0] MAX_VAL = '1;
  localparam logic [SIZE-1:0] ONE     = SIZE'(1);

  logic [SIZE-1:0] nxt_bin;
  logic [SIZE-1:0] nxt_gray;
  logic            nxt_wrap;

  // Step arithmetic runs on the binary shadow so Gray never needs decoding.
  always_comb begin
    nxt_bin  = cnt_bin;
    nxt_wrap = 1'b0;
    if (clr) begin
      nxt_bin = '0;
    end else if (load) begin
      nxt_bin = load_bin;
    end else if (en) begin
      if (up) begin
        if (cnt_bin == MAX_VAL) begin
          if (MODE != MODE_SAT) begin
            nxt_bin  = '0;
            nxt_wrap = 1'b1;
          end
        end else begin
          nxt_bin = cnt_bin + ONE;
        end
      end else begin
        if (cnt_bin == '0) begin
          if (MODE != MODE_SAT) begin
            nxt_bin  = MAX_VAL;
            nxt_wrap = 1'b1;
          end
        end else begin
          nxt_bin = cnt_bin - ONE;
        end
      end
    end
  end

  bin_to_gray #(.SIZE(SIZE)) u_b2g (
    .bin  (nxt_bin),
    .gray (nxt_gray)
  );

  assign cnt_gray_nxt = nxt_gray;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_bin  <= '0;
      cnt_gray <= '0;
      at_max   <= 1'b0;
      at_min   <= 1'b1;
      wrap     <= 1'b0;
    end else begin
      cnt_bin  <= nxt_bin;
      cnt_gray <= nxt_gray;
      at_max   <= (nxt_bin == MAX_VAL);
      at_min   <= (nxt_bin == '0);
      wrap     <= nxt_wrap;
    end
  end

endmodule

// File: tb/tb_gray_updown_cnt.sv
// tb/tb_gray_updown_cnt.sv - directed bench for wrap and saturate counter instances
module tb_gray_updown_cnt;
  import gray_updown_cnt_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       up;
  logic       clr;
  logic       load;
  logic [3:0] load_bin;

  logic [3:0] gray_w, bin_w, nxt_w, dec_w;
  logic       max_w, min_w, wrap_w;
  logic [3:0] gray_s, bin_s, nxt_s, dec_s;
  logic       max_s, min_s, wrap_s;

  int vectors;
  int miscompares;

  logic [3:0] gseq [16];

  gray_updown_cnt #(.SIZE(4), .MODE(MODE_WRAP)) dut_w (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .clr(clr), .load(load),
    .load_bin(load_bin), .cnt_gray(gray_w), .cnt_bin(bin_w),
    .cnt_gray_nxt(nxt_w), .at_max(max_w), .at_min(min_w), .wrap(wrap_w)
  );

  gray_updown_cnt #(.SIZE(4), .MODE(MODE_SAT)) dut_s (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .clr(clr), .load(load),
    .load_bin(load_bin), .cnt_gray(gray_s), .cnt_bin(bin_s),
    .cnt_gray_nxt(nxt_s), .at_max(max_s), .at_min(min_s), .wrap(wrap_s)
  );

  gray_to_bin #(.SIZE(4)) u_g2b_w (.gray(gray_w), .bin(dec_w));
  gray_to_bin #(.SIZE(4)) u_g2b_s (.gray(gray_s), .bin(dec_s));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    en = 1'b0; up = 1'b0; clr = 1'b0; load = 1'b0; load_bin = 4'd0;
  endtask

  task automatic do_clear();
    idle_inputs();
    clr = 1'b1;
    step();
    clr = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #3;
    vectors++;
    if ({gray_w, bin_w, min_w, max_w, wrap_w} !== {4'd0, 4'd0, 1'b1, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_w: got gray=%0d bin=%0d min=%0b max=%0b wrap=%0b want 0 0 1 0 0",
               gray_w, bin_w, min_w, max_w, wrap_w);
    end
    vectors++;
    if ({gray_s, bin_s, min_s, max_s, wrap_s} !== {4'd0, 4'd0, 1'b1, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_s: got gray=%0d bin=%0d min=%0b max=%0b wrap=%0b want 0 0 1 0 0",
               gray_s, bin_s, min_s, max_s, wrap_s);
    end
    #8 rst_n = 1'b1;
    en = 1'b1; up = 1'b1;
    for (int i = 0; i < 9; i++) step();
    vectors++;
    if (bin_w !== 4'd9 || gray_w !== 4'd13) begin
      miscompares++;
      $display("FAIL pre_reset_count: got bin=%0d gray=%0d want 9 13", bin_w, gray_w);
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({gray_w, bin_w, min_w, max_w, wrap_w} !== {4'd0, 4'd0, 1'b1, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_mid: got gray=%0d bin=%0d min=%0b max=%0b wrap=%0b want 0 0 1 0 0",
               gray_w, bin_w, min_w, max_w, wrap_w);
    end
    idle_inputs();
    #1 rst_n = 1'b1;
  endtask

  task automatic test_wrap_up();
    logic [3:0] prev;
    int         wraps;
    int         eb;
    do_clear();
    prev  = gray_w;
    wraps = 0;
    en = 1'b1; up = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      step();
      eb = i % 16;
      vectors++;
      if (gray_w !== gseq[eb] || bin_w !== 4'(eb)) begin
        miscompares++;
        $display("FAIL wrap_up_count[%0d]: got gray=%0d bin=%0d want gray=%0d bin=%0d",
                 i, gray_w, bin_w, gseq[eb], eb);
      end
      vectors++;
      if ($countones(gray_w ^ prev) != 1) begin
        miscompares++;
        $display("FAIL wrap_up_hamming[%0d]: got prev=%0d cur=%0d want distance 1", i, prev, gray_w);
      end
      vectors++;
      if (wrap_w !== (eb == 0) || max_w !== (eb == 15) || min_w !== (eb == 0)) begin
        miscompares++;
        $display("FAIL wrap_up_flags[%0d]: got wrap=%0b max=%0b min=%0b want %0b %0b %0b",
                 i, wrap_w, max_w, min_w, eb == 0, eb == 15, eb == 0);
      end
      vectors++;
      if (dec_w !== bin_w) begin
        miscompares++;
        $display("FAIL wrap_up_shadow[%0d]: got bin=%0d want %0d", i, bin_w, dec_w);
      end
      vectors++;
      if (bin_s !== ((i > 15) ? 4'd15 : 4'(i)) || wrap_s !== 1'b0) begin
        miscompares++;
        $display("FAIL sat_up_track[%0d]: got bin=%0d wrap=%0b want %0d 0",
                 i, bin_s, wrap_s, (i > 15) ? 15 : i);
      end
      if (wrap_w) wraps++;
      prev = gray_w;
    end
    vectors++;
    if (wraps != 1) begin
      miscompares++;
      $display("FAIL wrap_up_pulses: got %0d want 1", wraps);
    end
    idle_inputs();
  endtask

  task automatic test_wrap_down();
    do_clear();
    en = 1'b1; up = 1'b0;
    step();
    vectors++;
    if ({bin_w, gray_w, wrap_w, max_w, min_w} !== {4'd15, 4'b1000, 1'b1, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL wrap_down_edge: got bin=%0d gray=%b wrap=%0b max=%0b min=%0b want 15 1000 1 1 0",
               bin_w, gray_w, wrap_w, max_w, min_w);
    end
    vectors++;
    if ({bin_s, wrap_s, min_s} !== {4'd0, 1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL sat_down_floor: got bin=%0d wrap=%0b min=%0b want 0 0 1", bin_s, wrap_s, min_s);
    end
    step();
    vectors++;
    if ({bin_w, gray_w, wrap_w, max_w} !== {4'd14, 4'b1001, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL wrap_down_next: got bin=%0d gray=%b wrap=%0b max=%0b want 14 1001 0 0",
               bin_w, gray_w, wrap_w, max_w);
    end
    idle_inputs();
  endtask

  task automatic test_saturate();
    idle_inputs();
    load = 1'b1; load_bin = 4'd14;
    step();
    load = 1'b0;
    en = 1'b1; up = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++;
      if ({bin_s, gray_s, max_s, wrap_s} !== {4'd15, 4'b1000, 1'b1, 1'b0}) begin
        miscompares++;
        $display("FAIL sat_up_hold[%0d]: got bin=%0d gray=%b max=%0b wrap=%0b want 15 1000 1 0",
                 i, bin_s, gray_s, max_s, wrap_s);
      end
    end
    vectors++;
    if (bin_w !== 4'd1) begin
      miscompares++;
      $display("FAIL wrap_load_count: got bin=%0d want 1", bin_w);
    end
    idle_inputs();
    load = 1'b1; load_bin = 4'd1;
    step();
    load = 1'b0;
    en = 1'b1; up = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++;
      if ({bin_s, gray_s, min_s, wrap_s} !== {4'd0, 4'd0, 1'b1, 1'b0}) begin
        miscompares++;
        $display("FAIL sat_down_hold[%0d]: got bin=%0d gray=%0d min=%0b wrap=%0b want 0 0 1 0",
                 i, bin_s, gray_s, min_s, wrap_s);
      end
    end
    idle_inputs();
  endtask

  task automatic test_priority();
    idle_inputs();
    load = 1'b1; load_bin = 4'd9;
    step();
    clr = 1'b1; load = 1'b1; load_bin = 4'd7; en = 1'b1; up = 1'b1;
    step();
    vectors++;
    if ({bin_w, gray_w, bin_s, gray_s} !== 16'h0000) begin
      miscompares++;
      $display("FAIL priority_clr: got w=%0d/%0d s=%0d/%0d want 0", bin_w, gray_w, bin_s, gray_s);
    end
    idle_inputs();
    load = 1'b1; load_bin = 4'd7;
    step();
    vectors++;
    if ({bin_w, gray_w, wrap_w} !== {4'd7, 4'b0100, 1'b0}) begin
      miscompares++;
      $display("FAIL priority_load: got bin=%0d gray=%b wrap=%0b want 7 0100 0", bin_w, gray_w, wrap_w);
    end
    load = 1'b0; en = 1'b1; up = 1'b1; load_bin = 4'd3;
    step();
    vectors++;
    if (bin_w !== 4'd8 || gray_w !== 4'b1100) begin
      miscompares++;
      $display("FAIL load_then_step: got bin=%0d gray=%b want 8 1100", bin_w, gray_w);
    end
    idle_inputs();
  endtask

  task automatic test_lookahead();
    logic [3:0] exp_w, exp_s;
    int         bad;
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      en       = ($urandom_range(3) != 0);
      up       = $urandom_range(1);
      clr      = ($urandom_range(31) == 0);
      load     = ($urandom_range(15) == 0);
      load_bin = 4'($urandom_range(15));
      #1;
      exp_w = nxt_w;
      exp_s = nxt_s;
      step();
      vectors++;
      if (gray_w !== exp_w || gray_s !== exp_s) begin
        miscompares++;
        bad++;
        if (bad <= 5)
          $display("FAIL lookahead[%0d]: got w=%0d s=%0d want w=%0d s=%0d", i, gray_w, gray_s, exp_w, exp_s);
      end
      vectors++;
      if (dec_w !== bin_w || dec_s !== bin_s) begin
        miscompares++;
        bad++;
        if (bad <= 5)
          $display("FAIL shadow[%0d]: got w=%0d s=%0d want w=%0d s=%0d", i, bin_w, bin_s, dec_w, dec_s);
      end
    end
    idle_inputs();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    gseq = '{4'd0, 4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4,
             4'd12, 4'd13, 4'd15, 4'd14, 4'd10, 4'd11, 4'd9, 4'd8};
    test_reset();
    test_wrap_up();
    test_wrap_down();
    test_saturate();
    test_priority();
    test_lookahead();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
